// File: rtl/nack_wrr_pkt_arbiter_if.sv
// Request fan-in bundle between NACK requesters and the weighted round-robin arbiter.
interface nack_wrr_pkt_arbiter_if #(
   parameter int unsigned N  = 16,
   parameter int unsigned WW = 4,
   parameter int unsigned IW = $clog2(N)
);
   logic [N-1:0]    req;
   logic [N-1:0]    last;
   logic [N*WW-1:0] weight;
   logic            out_ready;
   logic [N-1:0]    grant;
   logic [IW-1:0]   grant_idx;
   logic            grant_valid;

   modport master (
      output req, last, weight, out_ready,
      input  grant, grant_idx, grant_valid
   );

   modport slave (
      input  req, last, weight, out_ready,
      output grant, grant_idx, grant_valid
   );
endinterface

// File: rtl/nack_wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter: zero-latency grant, packet locking,
// per-requester packet credits and a valid/ready handshake downstream.
module nack_wrr_pkt_arbiter #(
   parameter  int unsigned N  = 16,
   parameter  int unsigned WW = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input logic                clk,
   input logic                rst,
   nack_wrr_pkt_arbiter_if.slave bus
);

   typedef enum logic {ST_OPEN, ST_LOCKED} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [WW-1:0]   credit_q, credit_d;
   logic [IW-1:0]   lock_idx_q, lock_idx_d;

   logic            scan_hit;
   logic [IW-1:0]   scan_idx;
   logic [IW-1:0]   sel;
   logic [N-1:0]    grant_c;
   logic [IW-1:0]   grant_idx_c;
   logic            grant_valid_c;
   logic            xfer;
   logic [WW:0]     used;
   logic [WW:0]     w_eff;
   logic [WW-1:0]   w_sel;

   // First requester at or after ptr, wrapping through N-1 back to 0.
   always_comb begin : sel_scan
      int unsigned j;
      scan_hit = 1'b0;
      scan_idx = '0;
      j        = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr_q) + k;
         if (j >= N) j = j - N;
         if (!scan_hit && bus.req[IW'(j)]) begin
            scan_hit = 1'b1;
            scan_idx = IW'(j);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_OPEN;
         ptr_q      <= '0;
         credit_q   <= '0;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         credit_q   <= credit_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   // Output logic
   always_comb begin
      sel           = '0;
      grant_c       = '0;
      grant_idx_c   = '0;
      grant_valid_c = 1'b0;
      if (!rst) begin
         if (state_q == ST_LOCKED) begin
            sel                 = lock_idx_q;
            grant_c[lock_idx_q] = 1'b1;
            grant_idx_c         = lock_idx_q;
            grant_valid_c       = bus.req[lock_idx_q];
         end else if (scan_hit) begin
            sel               = scan_idx;
            grant_c[scan_idx] = 1'b1;
            grant_idx_c       = scan_idx;
            grant_valid_c     = 1'b1;
         end
      end
   end

   assign bus.grant       = grant_c;
   assign bus.grant_idx   = grant_idx_c;
   assign bus.grant_valid = grant_valid_c;

   // Next-state logic; a turn change (sel != ptr) discards the old owner's credit.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      credit_d   = credit_q;
      lock_idx_d = lock_idx_q;
      xfer       = grant_valid_c & bus.out_ready;
      used       = (sel == ptr_q) ? ({1'b0, credit_q} + 1'b1) : (WW+1)'(1);
      w_sel      = bus.weight[32'(sel)*WW +: WW];
      w_eff      = (w_sel == '0) ? (WW+1)'(1) : {1'b0, w_sel};
      if (xfer) begin
         if (!bus.last[sel]) begin
            state_d    = ST_LOCKED;
            lock_idx_d = sel;
         end else begin
            state_d = ST_OPEN;
            if (used >= w_eff) begin
               ptr_d    = (sel == IW'(N-1)) ? '0 : sel + 1'b1;
               credit_d = '0;
            end else begin
               ptr_d    = sel;
               credit_d = used[WW-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_nack_wrr_pkt_arbiter.sv
// Directed bench for nack_wrr_pkt_arbiter with N=4, WW=4.
module tb_nack_wrr_pkt_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned WW = 4;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   nack_wrr_pkt_arbiter_if #(.N(N), .WW(WW)) bus ();

   nack_wrr_pkt_arbiter #(.N(N), .WW(WW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_weights(input logic [3:0] w0, input logic [3:0] w1,
                              input logic [3:0] w2, input logic [3:0] w3);
      bus.weight = {w3, w2, w1, w0};
   endtask

   initial begin
      logic [31:0] seq3 [9];
      logic [N-1:0] last4 [6];
      logic         rdy4  [6];
      seq3  = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
      last4 = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011};
      rdy4  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      // 1: reset forces outputs low, idle after reset
      rst = 1'b1;
      bus.req = 4'b1111;
      bus.last = 4'b1111;
      bus.out_ready = 1'b1;
      set_weights(1, 1, 1, 1);
      #1;
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_valid", 32'(bus.grant_valid), 32'h0);
      chk("rst_idx", 32'(bus.grant_idx), 32'h0);
      tick();
      rst = 1'b0;
      bus.req = 4'b0000;
      #1;
      chk("idle_grant", 32'(bus.grant), 32'h0);
      chk("idle_idx", 32'(bus.grant_idx), 32'h0);
      chk("idle_valid", 32'(bus.grant_valid), 32'h0);

      // 2: plain round robin, weights 1
      bus.req = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("rr_idx%0d", i), 32'(bus.grant_idx), 32'(i % 4));
         tick();
      end

      // 3: weight0=3, then weight0=0 behaves as 1
      do_reset();
      set_weights(3, 1, 1, 1);
      for (int i = 0; i < 9; i++) begin
         #1;
         chk($sformatf("w3_idx%0d", i), 32'(bus.grant_idx), seq3[i]);
         tick();
      end
      do_reset();
      set_weights(0, 1, 1, 1);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("w0_idx%0d", i), 32'(bus.grant_idx), 32'(i));
         tick();
      end

      // 4: 4-beat packet on idx0 holds grant through back-pressure
      do_reset();
      set_weights(1, 1, 1, 1);
      bus.req = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         bus.last = last4[i];
         bus.out_ready = rdy4[i];
         #1;
         chk($sformatf("pkt_grant%0d", i), 32'(bus.grant), 32'h1);
         tick();
      end
      #1;
      chk("pkt_after_grant", 32'(bus.grant), 32'h2);
      chk("pkt_after_idx", 32'(bus.grant_idx), 32'h1);

      // 5: stall keeps grant and state stable, then transfer on idx1
      do_reset();
      bus.req = 4'b0110;
      bus.last = 4'b1111;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("stall_grant%0d", i), 32'(bus.grant), 32'h2);
         tick();
      end
      chk("stall_valid", 32'(bus.grant_valid), 32'h1);
      chk("stall_ptr", 32'(dut.ptr_q), 32'h0);
      chk("stall_credit", 32'(dut.credit_q), 32'h0);
      bus.out_ready = 1'b1;
      tick();
      chk("xfer_ptr", 32'(dut.ptr_q), 32'h2);
      #1;
      chk("xfer_next_grant", 32'(bus.grant), 32'h4);

      // 6: lock on idx2, ignore others, drop req, reset mid-packet
      bus.req = 4'b0100;
      bus.last = 4'b0000;
      tick();
      bus.req = 4'b0011;
      #1;
      chk("lock_hold_grant", 32'(bus.grant), 32'h4);
      chk("lock_other_valid", 32'(bus.grant_valid), 32'h0);
      bus.req = 4'b0000;
      #1;
      chk("drop_grant", 32'(bus.grant), 32'h4);
      chk("drop_valid", 32'(bus.grant_valid), 32'h0);
      tick();
      bus.req = 4'b0100;
      #1;
      chk("resume_valid", 32'(bus.grant_valid), 32'h1);
      rst = 1'b1;
      #1;
      chk("midrst_grant", 32'(bus.grant), 32'h0);
      tick();
      rst = 1'b0;
      bus.req = 4'b0110;
      #1;
      chk("postrst_grant", 32'(bus.grant), 32'h2);
      chk("postrst_idx", 32'(bus.grant_idx), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nack_wrr_pkt_arbiter.md
Name: nack_wrr_pkt_arbiter

Overview:
Parametrised weighted round-robin arbiter for the NACK generator's request fan-in. Successor to the single-cycle round-robin core, with three additions:
- Per-requester packet weights: up to WEIGHT[i] consecutive packets per turn.
- Packet locking: the grant is held from the first beat to the beat flagged last.
- A valid/ready handshake toward the downstream consumer.

Grant is combinational (zero-latency). Pointer, credit and lock state are registered.

Parameters:
N, 16, number of requesters (N >= 2).
WW, 4, width of each weight field and of the credit counter.
IW, $clog2(N), width of grant_idx (derived; do not override).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
req  in  N  per-requester request/valid, held until transferred.
last  in  N  per-requester last-beat flag, qualified by req.
weight  in  N*WW  packets per turn; field i = weight[i*WW +: WW]; value 0 is treated as 1.
out_ready  in  1  downstream accepts the granted beat.
grant  out  N  one-hot grant, or all zeros.
grant_idx  out  IW  index of the granted requester; 0 when grant == 0.
grant_valid  out  1  granted requester currently has req asserted.

Behaviour:
- State registers:
  - ptr (IW bits): owner / highest-priority index.
  - credit (WW bits): packets already completed by the owner in this turn.
  - locked (1 bit).
  - lock_idx (IW bits).
- Reset: while rst = 1, grant, grant_idx and grant_valid are forced to 0. Registers take ptr=0, credit=0, locked=0, lock_idx=0 on the next edge. A reset mid-packet drops the lock with no further grant to that packet.
- Selection when unlocked: sel = first i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - grant = onehot(sel) if |req, else 0.
  - grant_valid = |req.
- Selection when locked: sel = lock_idx.
  - grant = onehot(lock_idx) unconditionally.
  - grant_valid = req[lock_idx].
  - Other requests are ignored.
- Transfer: xfer = grant_valid & out_ready. With no xfer, all registers hold.
- On xfer with last[sel]=0: locked <= 1, lock_idx <= sel.
- On xfer with last[sel]=1 (packet end): locked <= 0, then the credit update:
  - used = (sel == ptr) ? credit + 1 : 1.
  - Compute in WW+1 bits; w = max(weight[sel], 1), sampled at this edge.
  - If used >= w: ptr <= (sel + 1) mod N, credit <= 0.
  - Else: ptr <= sel, credit <= used[WW-1:0].
- A single-beat packet (last=1 on its first beat) never sets locked.
- ptr wrap: N-1 advances to 0.
- Owner drops req with credit left: the scan moves past it. The next packet end is from sel != ptr, so the new owner starts at used=1 and the old credit is discarded.
- Weight changes apply at the next packet-end comparison. A packet in flight is never cut.
- The downstream must see a stable grant/grant_idx while grant_valid=1 and out_ready=0. The block guarantees this: no state changes without xfer, and requesters must hold req.
- req dropped mid-packet (locked): grant stays on lock_idx with grant_valid=0 until req returns.

Test Plan:
1. rst=1 with req=4'b1111 (N=4) -> grant=0, grant_valid=0. After rst=0, req=4'b0000 -> grant=0, grant_idx=0, grant_valid=0.
2. N=4, all weights 1, req=1111, last=1111, out_ready=1 held -> grant_idx sequence 0,1,2,3,0,1 on consecutive cycles.
3. weight0=3, others=1, req=1111 single-beat -> grant_idx 0,0,0,1,2,3,0,0,0. weight0=0 -> behaves as 1: 0,1,2,3.
4. Requester 0 sends a 4-beat packet (last on beat 4), req1 asserted throughout, out_ready pattern 1,0,1,1,0,1 -> grant stays 0001 for all six cycles, then 0010 on the cycle after the last-beat transfer.
5. out_ready=0 for 5 cycles with req=0110 -> grant=0010 stable, ptr/credit unchanged. Then out_ready=1 -> transfer on idx1.
6. Locked on idx2 mid-packet, assert rst for 1 cycle, then req=0110 -> grant=0010 (ptr=0, lock cleared). Also: idx2 drops req mid-packet -> grant_valid=0, grant holds 0100.
